// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding the IF/ID pipeline register.
//
// Generates the PC and issues single outstanding requests on the
// instruction bus. Each returned word is presented to IF/ID together with
// its address. It supports a downstream hold, a jump redirect that discards
// in-flight responses, and a one-entry buffer that catches a response
// arriving while the hold is asserted.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   stall_i        downstream hold, IF/ID outputs frozen while high
//   jump_i         redirect pulse, jump_addr_i is the target (bits [1:0] ignored)
//   ibus_req_o     fetch request (S_REQ only)
//   ibus_addr_o    fetch address, stable until granted
//   ibus_gnt_i     request accepted this cycle
//   ibus_rvalid_i  read data valid
//   ibus_rdata_i   instruction word
//   inst_o         instruction to IF/ID (NOP_INST when not valid)
//   inst_addr_o    address of inst_o
//   inst_valid_o   inst_o is a real fetched instruction
//
// state  | meaning
// S_RST  | first cycle after reset release, no request yet
// S_REQ  | request driven at ibus_addr_o, waiting for grant
// S_WAIT | granted, waiting for rvalid
// S_HOLD | response held in the buffer while stall_i is high

`ifndef INST_NOP
`define INST_NOP 32'h0000_0001
`endif

module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = `INST_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_req_pc;
  logic [31:0] w_req_pc_nxt;
  logic        r_discard;
  logic        w_discard_nxt;
  // Set when a jump lands while a request is still waiting for its grant:
  // the bus address must not change, so the request keeps presenting
  // r_req_pc while r_pc already holds the jump target.
  logic        r_addr_lock;
  logic        w_addr_lock_nxt;

  // One-entry response buffer; it is occupied exactly when r_state is
  // S_HOLD, so leaving S_HOLD is what empties it.
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_addr;
  logic        w_buf_we;

  logic        w_out_vld;
  logic [31:0] w_out_inst;
  logic [31:0] w_out_addr;
  logic        w_out_upd;

  logic [31:0] r_inst;
  logic [31:0] r_inst_addr;
  logic        r_inst_valid;

  logic [31:0] w_jump_tgt;
  logic [31:0] w_pc_inc;

  assign w_jump_tgt = jump_addr_i & ~32'h0000_0003;
  assign w_pc_inc   = r_pc + 32'd4;
  // A jump flushes the IF/ID outputs even while the stage is held.
  assign w_out_upd  = jump_i | ~stall_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RST;
      r_pc        <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_discard   <= 1'b0;
      r_addr_lock <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_pc    <= w_req_pc_nxt;
      r_discard   <= w_discard_nxt;
      r_addr_lock <= w_addr_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_pc_nxt    = r_req_pc;
    w_discard_nxt   = r_discard;
    w_addr_lock_nxt = r_addr_lock;
    w_buf_we        = 1'b0;
    w_out_vld       = 1'b0;
    w_out_inst      = r_buf_inst;
    w_out_addr      = r_buf_addr;

    case (r_state)
      S_RST: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (ibus_gnt_i) begin
          w_state_nxt     = S_WAIT;
          w_addr_lock_nxt = 1'b0;
          // With the address locked, r_req_pc already names the granted
          // transaction and r_pc already holds the redirect target.
          if (!r_addr_lock) begin
            w_req_pc_nxt = r_pc;
            w_pc_nxt     = w_pc_inc;
          end
        end
      end
      S_WAIT: begin
        if (ibus_rvalid_i) begin
          if (r_discard) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else if (!stall_i) begin
            w_out_vld   = 1'b1;
            w_out_inst  = ibus_rdata_i;
            w_out_addr  = r_req_pc;
            w_state_nxt = S_REQ;
          end else begin
            w_buf_we    = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          w_out_vld   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_RST;
      end
    endcase

    // Redirect wins over stall and over a same-cycle response.
    if (jump_i) begin
      w_pc_nxt  = w_jump_tgt;
      w_out_vld = 1'b0;
      w_buf_we  = 1'b0;
      case (r_state)
        S_REQ: begin
          // Granted or not, the transaction at the old address is dead.
          w_discard_nxt = 1'b1;
          if (!ibus_gnt_i) begin
            w_addr_lock_nxt = 1'b1;
            if (!r_addr_lock) w_req_pc_nxt = r_pc;
          end
        end
        S_WAIT: begin
          if (ibus_rvalid_i) begin
            w_discard_nxt = 1'b0;
            w_state_nxt   = S_REQ;
          end else begin
            w_discard_nxt = 1'b1;
            w_state_nxt   = S_WAIT;
          end
        end
        S_HOLD: begin
          w_state_nxt = S_REQ;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_inst <= NOP_INST;
      r_buf_addr <= 32'h0;
    end else if (w_buf_we) begin
      r_buf_inst <= ibus_rdata_i;
      r_buf_addr <= r_req_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst       <= NOP_INST;
      r_inst_addr  <= 32'h0;
      r_inst_valid <= 1'b0;
    end else if (w_out_upd) begin
      r_inst_valid <= w_out_vld;
      r_inst       <= w_out_vld ? w_out_inst : NOP_INST;
      // The address of a bubble is left at the last real instruction.
      if (w_out_vld) r_inst_addr <= w_out_addr;
    end
  end

  assign ibus_req_o   = (r_state == S_REQ);
  assign ibus_addr_o  = r_addr_lock ? r_req_pc : r_pc;
  assign inst_o       = r_inst;
  assign inst_addr_o  = r_inst_addr;
  assign inst_valid_o = r_inst_valid;

endmodule

// File: tb/tb_ifu_fetch.sv
`timescale 1ns/1ps
module tb_ifu_fetch;
  localparam logic [31:0] NOP   = 32'h0000_0001;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  logic        w2_req;
  logic [31:0] w2_addr;
  logic        w2_gnt;
  logic        w2_rvalid;
  logic [31:0] w2_rdata;
  logic [31:0] w2_inst;
  logic [31:0] w2_iaddr;
  logic        w2_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // bus responder knobs
  bit gnt_rand = 1'b0;
  int rv_delay = 0;
  bit stray    = 1'b0;

  always #5 clk = ~clk;

  ifu_fetch u_dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .jump_i(jump_i),
    .jump_addr_i(jump_addr_i), .ibus_req_o(ibus_req_o),
    .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  ifu_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .stall_i(1'b0), .jump_i(1'b0),
    .jump_addr_i(32'h0), .ibus_req_o(w2_req),
    .ibus_addr_o(w2_addr), .ibus_gnt_i(w2_gnt),
    .ibus_rvalid_i(w2_rvalid), .ibus_rdata_i(w2_rdata),
    .inst_o(w2_inst), .inst_addr_o(w2_iaddr), .inst_valid_o(w2_valid)
  );

  // Memory model for the main DUT: data word = address ^ XMASK,
  // rvalid rv_delay cycles after the grant cycle's following cycle.
  bit          pend, taken, rv_prev;
  logic [31:0] pend_addr, taken_addr;
  int          dly;
  always @(negedge clk) begin
    if (rst) begin
      pend = 0; taken = 0; rv_prev = 0;
      ibus_gnt_i = 0; ibus_rvalid_i = 0; ibus_rdata_i = 0;
    end else begin
      if (rv_prev) pend = 0;
      if (taken) begin pend = 1; pend_addr = taken_addr; dly = rv_delay; end
      rv_prev = 0;
      if (pend) begin
        if (dly == 0) rv_prev = 1;
        else dly--;
      end
      ibus_rvalid_i = rv_prev | stray;
      ibus_rdata_i  = rv_prev ? (pend_addr ^ XMASK) : 32'hDEAD_BEEF;
      ibus_gnt_i    = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      taken      = ibus_req_o && ibus_gnt_i;
      taken_addr = ibus_addr_o;
    end
  end

  // Zero-wait memory for the wrap-around instance.
  bit          w2_taken;
  logic [31:0] w2_taken_addr;
  always @(negedge clk) begin
    if (rst) begin
      w2_taken = 0; w2_gnt = 0; w2_rvalid = 0; w2_rdata = 0;
    end else begin
      w2_rvalid = w2_taken;
      w2_rdata  = w2_taken_addr ^ XMASK;
      w2_gnt    = 1'b1;
      w2_taken  = w2_req;
      w2_taken_addr = w2_addr;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1; stall_i = 0; jump_i = 0;
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (inst_o !== NOP) begin n_fail++; $display("FAIL rst_inst got %h want %h", inst_o, NOP); end
    n_checks++; if (inst_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", inst_addr_o); end
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", inst_valid_o); end
    n_checks++; if (ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", ibus_req_o); end
    rst = 0;
    @(posedge clk); #1;
    n_checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) begin
      n_fail++; $display("FAIL first_req got req %b addr %h want 1 00000000", ibus_req_o, ibus_addr_o);
    end
  endtask

  task automatic test_zero_wait();
    for (int i = 1; i <= 4; i++) begin
      logic [31:0] ea;
      @(posedge clk); #1;
      ea = 32'((i / 2 - 1) * 4);
      if (i % 2 == 0) begin
        n_checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== ea || inst_o !== (ea ^ XMASK)) begin
          n_fail++; $display("FAIL zw_deliver cyc %0d got v%b %h %h want v1 %h %h", i, inst_valid_o, inst_addr_o, inst_o, ea, ea ^ XMASK);
        end
      end else begin
        n_checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
          n_fail++; $display("FAIL zw_bubble cyc %0d got v%b %h want v0 %h", i, inst_valid_o, inst_o, NOP);
        end
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk); stall_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h4 || inst_o !== (32'h4 ^ XMASK)) begin
        n_fail++; $display("FAIL stall_frozen cyc %0d got v%b %h %h want v1 00000004", i, inst_valid_o, inst_addr_o, inst_o);
      end
      n_checks++; if (ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_noreq cyc %0d got req %b want 0", i, ibus_req_o); end
    end
    @(negedge clk); stall_i = 0;
    @(posedge clk); #1;
    n_checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h8 || inst_o !== (32'h8 ^ XMASK)) begin
      n_fail++; $display("FAIL stall_release got v%b %h %h want v1 00000008", inst_valid_o, inst_addr_o, inst_o);
    end
    @(posedge clk); #1;
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_nodup got v%b want 0", inst_valid_o); end
    @(posedge clk); #1;
    n_checks++; if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'hC) begin
      n_fail++; $display("FAIL stall_next got v%b %h want v1 0000000c", inst_valid_o, inst_addr_o);
    end
  endtask

  task automatic test_jump_wait();
    bit got_g, done;
    logic [31:0] g_addr;
    got_g = 0; done = 0; g_addr = 0;
    rv_delay = 2;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk); jump_i = 1; jump_addr_i = 32'h103;
    @(posedge clk); #1;
    n_checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
      n_fail++; $display("FAIL jw_flush got v%b %h want v0 %h", inst_valid_o, inst_o, NOP);
    end
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk); jump_i = 0; rv_delay = 0; #1;
      if (!got_g && ibus_req_o && ibus_gnt_i) begin got_g = 1; g_addr = ibus_addr_o; end
      @(posedge clk); #1;
      if (inst_valid_o) done = 1;
    end
    n_checks++; if (!got_g || g_addr !== 32'h100) begin
      n_fail++; $display("FAIL jw_req got seen %b addr %h want 00000100", got_g, g_addr);
    end
    n_checks++; if (!done || inst_addr_o !== 32'h100 || inst_o !== (32'h100 ^ XMASK)) begin
      n_fail++; $display("FAIL jw_deliver got seen %b %h %h want 00000100", done, inst_addr_o, inst_o);
    end
  endtask

  task automatic test_jump_gnt();
    bit found, got_g, done;
    logic [31:0] g_addr;
    found = 0; got_g = 0; done = 0; g_addr = 0;
    @(negedge clk); jump_i = 1; jump_addr_i = 32'h20;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); jump_i = 0; #1;
      if (ibus_req_o && ibus_gnt_i && ibus_addr_o == 32'h20) begin found = 1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL jg_reach got no grant at 00000020 want one"); end
    jump_i = 1; jump_addr_i = 32'h40;
    @(posedge clk); #1;
    n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL jg_flush got v%b want 0", inst_valid_o); end
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk); jump_i = 0; #1;
      if (!got_g && ibus_req_o && ibus_gnt_i) begin got_g = 1; g_addr = ibus_addr_o; end
      @(posedge clk); #1;
      if (inst_valid_o) done = 1;
    end
    n_checks++; if (!got_g || g_addr !== 32'h40) begin
      n_fail++; $display("FAIL jg_req got seen %b addr %h want 00000040", got_g, g_addr);
    end
    n_checks++; if (!done || inst_addr_o !== 32'h40 || inst_o !== (32'h40 ^ XMASK)) begin
      n_fail++; $display("FAIL jg_deliver got seen %b %h %h want 00000040", done, inst_addr_o, inst_o);
    end
  endtask

  task automatic test_hold_jump();
    bit found, got_g, done;
    logic [31:0] g_addr;
    found = 0; got_g = 0; done = 0; g_addr = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); jump_i = 0;
      @(posedge clk); #1;
      if (inst_valid_o) begin found = 1; break; end
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL hj_reach got no delivery want one"); end
    @(negedge clk); stall_i = 1;
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    n_checks++; if (ibus_req_o !== 1'b0 || inst_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL hj_hold got req %b v%b want req 0 v1", ibus_req_o, inst_valid_o);
    end
    @(negedge clk); jump_i = 1; jump_addr_i = 32'h200;
    @(posedge clk); #1;
    n_checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
      n_fail++; $display("FAIL hj_flush got v%b %h want v0 %h", inst_valid_o, inst_o, NOP);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); jump_i = 0; #1;
      if (!got_g && ibus_req_o && ibus_gnt_i) begin got_g = 1; g_addr = ibus_addr_o; end
      @(posedge clk); #1;
      n_checks++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL hj_stalled cyc %0d got v%b want 0", c, inst_valid_o); end
    end
    n_checks++; if (!got_g || g_addr !== 32'h200) begin
      n_fail++; $display("FAIL hj_req got seen %b addr %h want 00000200", got_g, g_addr);
    end
    @(negedge clk); stall_i = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(posedge clk); #1;
      if (inst_valid_o) done = 1;
      else @(negedge clk);
    end
    n_checks++; if (!done || inst_addr_o !== 32'h200 || inst_o !== (32'h200 ^ XMASK)) begin
      n_fail++; $display("FAIL hj_deliver got seen %b %h %h want 00000200", done, inst_addr_o, inst_o);
    end
  endtask

  task automatic test_reset_mid();
    bit done;
    done = 0;
    rv_delay = 3;
    @(negedge clk);
    @(posedge clk); #1;
    #2 rst = 1; #1;
    n_checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0 || ibus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL rm_async got v%b %h %h req %b want v0 %h 00000000 req 0", inst_valid_o, inst_o, inst_addr_o, ibus_req_o, NOP);
    end
    @(negedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    stray = 1;
    @(negedge clk); #1; stray = 0;
    @(posedge clk); #1;
    n_checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
      n_fail++; $display("FAIL rm_stray got v%b %h want v0 %h", inst_valid_o, inst_o, NOP);
    end
    rv_delay = 0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(posedge clk); #1;
      if (inst_valid_o) done = 1;
    end
    n_checks++; if (!done || inst_addr_o !== 32'h0 || inst_o !== XMASK) begin
      n_fail++; $display("FAIL rm_first got seen %b %h %h want 00000000 %h", done, inst_addr_o, inst_o, XMASK);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ga[3];
    logic [31:0] da[3];
    int ng, nd;
    ng = 0; nd = 0;
    apply_reset();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk); #1;
      if (w2_req && w2_gnt && ng < 3) begin ga[ng] = w2_addr; ng++; end
      @(posedge clk); #1;
      if (w2_valid && nd < 3) begin
        da[nd] = w2_iaddr;
        n_checks++; if (w2_inst !== (w2_iaddr ^ XMASK)) begin
          n_fail++; $display("FAIL wrap_data got %h want %h", w2_inst, w2_iaddr ^ XMASK);
        end
        nd++;
      end
    end
    n_checks++; if (ng != 3 || nd != 3) begin n_fail++; $display("FAIL wrap_count got %0d/%0d want 3/3", ng, nd); end
    for (int k = 0; k < 3 && k < ng && k < nd; k++) begin
      logic [31:0] e;
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      n_checks++; if (ga[k] !== e) begin n_fail++; $display("FAIL wrap_req %0d got %h want %h", k, ga[k], e); end
      n_checks++; if (da[k] !== e) begin n_fail++; $display("FAIL wrap_out %0d got %h want %h", k, da[k], e); end
    end
  endtask

  // Reference model: the delivered stream is program order starting at the
  // reset PC, restarting at each jump target; anything in flight is lost.
  task automatic test_random();
    logic [31:0] exp_addr, pre_addr, pre_jaddr, pre_inst, pre_iaddr;
    bit pre_stall, pre_jump, pre_req, pre_gnt, pre_valid, prev_jump;
    int deliveries;
    exp_addr = 32'h0; deliveries = 0; prev_jump = 0;
    gnt_rand = 1;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rv_delay = $urandom_range(0, 3);
      stall_i = ($urandom_range(0, 9) < 3);
      jump_i = !prev_jump && ($urandom_range(0, 19) == 0);
      jump_addr_i = $urandom;
      prev_jump = jump_i;
      #1;
      pre_stall = stall_i; pre_jump = jump_i; pre_jaddr = jump_addr_i;
      pre_req = ibus_req_o; pre_gnt = ibus_gnt_i; pre_addr = ibus_addr_o;
      pre_inst = inst_o; pre_iaddr = inst_addr_o; pre_valid = inst_valid_o;
      @(posedge clk); #1;
      if (pre_jump) begin
        n_checks++; if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
          n_fail++; $display("FAIL rnd_jump_flush cyc %0d got v%b %h want v0 %h", c, inst_valid_o, inst_o, NOP);
        end
        exp_addr = pre_jaddr & ~32'h3;
      end else if (pre_stall) begin
        n_checks++; if (inst_o !== pre_inst || inst_addr_o !== pre_iaddr || inst_valid_o !== pre_valid) begin
          n_fail++; $display("FAIL rnd_stall_hold cyc %0d got v%b %h %h want v%b %h %h", c, inst_valid_o, inst_addr_o, inst_o, pre_valid, pre_iaddr, pre_inst);
        end
      end else if (inst_valid_o) begin
        n_checks++; if (inst_addr_o !== exp_addr || inst_o !== (exp_addr ^ XMASK)) begin
          n_fail++; $display("FAIL rnd_order cyc %0d got %h %h want %h %h", c, inst_addr_o, inst_o, exp_addr, exp_addr ^ XMASK);
        end
        exp_addr = exp_addr + 32'd4;
        deliveries++;
      end else begin
        n_checks++; if (inst_o !== NOP) begin n_fail++; $display("FAIL rnd_nop cyc %0d got %h want %h", c, inst_o, NOP); end
      end
      if (pre_req && !pre_gnt) begin
        n_checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== pre_addr) begin
          n_fail++; $display("FAIL rnd_bus_hold cyc %0d got req %b %h want req 1 %h", c, ibus_req_o, ibus_addr_o, pre_addr);
        end
      end
    end
    n_checks++; if (deliveries < 80) begin n_fail++; $display("FAIL rnd_progress got %0d deliveries want >= 80", deliveries); end
    gnt_rand = 0; stall_i = 0; jump_i = 0;
  endtask

  initial begin
    rst = 1; stall_i = 0; jump_i = 0; jump_addr_i = 0;
    test_reset();
    test_zero_wait();
    test_stall();
    test_jump_wait();
    test_jump_gnt();
    test_hold_jump();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
